// File: rtl/branch_predict_resolve_if.sv
// Pipeline-to-branch-unit bus: IF prediction lookup, EX resolution inputs and redirect/statistics outputs.
interface branch_predict_resolve_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 16
);
    logic [XLEN-1:0]  pred_pc;
    logic             pred_taken;
    logic             ex_valid;
    logic             ex_branch;
    logic             ex_jump;
    logic [2:0]       ex_func3;
    logic [XLEN-1:0]  ex_data1;
    logic [XLEN-1:0]  ex_data2;
    logic [XLEN-1:0]  ex_pc;
    logic [XLEN-1:0]  ex_target;
    logic             ex_pred_taken;
    logic             stall;
    logic             redirect_valid;
    logic [XLEN-1:0]  redirect_pc;
    logic [CNT_W-1:0] mispredict_count;

    modport master (
        output pred_pc, ex_valid, ex_branch, ex_jump, ex_func3, ex_data1, ex_data2,
               ex_pc, ex_target, ex_pred_taken, stall,
        input  pred_taken, redirect_valid, redirect_pc, mispredict_count
    );

    modport slave (
        input  pred_pc, ex_valid, ex_branch, ex_jump, ex_func3, ex_data1, ex_data2,
               ex_pc, ex_target, ex_pred_taken, stall,
        output pred_taken, redirect_valid, redirect_pc, mispredict_count
    );
endinterface

// File: rtl/branch_predict_resolve.sv
// Branch unit: 2-bit BHT prediction in IF, branch/jump resolution in EX,
// registered one-cycle redirect on mispredict and a saturating mispredict counter.
module branch_predict_resolve #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned BHT_ENTRIES = 16,
    parameter int unsigned CNT_W       = 16
) (
    input logic CLK,
    input logic RESET,
    branch_predict_resolve_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);

    logic [1:0]       bht [BHT_ENTRIES];
    logic             shadow;
    logic [IDX_W-1:0] pred_idx_c;
    logic [IDX_W-1:0] ex_idx_c;
    logic             cond_c;
    logic             actual_taken_c;
    logic             resolve_c;
    logic             branch_only_c;
    logic             mispredict_c;
    logic [1:0]       bht_next_c;
    logic             unused_pc_bits;

    assign pred_idx_c      = bus.pred_pc[IDX_W+1:2];
    assign ex_idx_c        = bus.ex_pc[IDX_W+1:2];
    assign bus.pred_taken  = bht[pred_idx_c][1];
    assign unused_pc_bits  = ^{bus.pred_pc[XLEN-1:IDX_W+2], bus.pred_pc[1:0]};

    // Branch condition on the forwarded operands
    always_comb begin
        cond_c = 1'b0;
        case (bus.ex_func3)
            3'b000:  cond_c = (bus.ex_data1 == bus.ex_data2);
            3'b001:  cond_c = (bus.ex_data1 != bus.ex_data2);
            3'b100:  cond_c = ($signed(bus.ex_data1) <  $signed(bus.ex_data2));
            3'b101:  cond_c = ($signed(bus.ex_data1) >= $signed(bus.ex_data2));
            3'b110:  cond_c = (bus.ex_data1 <  bus.ex_data2);
            3'b111:  cond_c = (bus.ex_data1 >= bus.ex_data2);
            default: cond_c = 1'b0;
        endcase
    end

    // Jumps win over branches and always mispredict since there is no BTB
    always_comb begin
        actual_taken_c = bus.ex_jump | (bus.ex_branch & cond_c);
        branch_only_c  = bus.ex_branch & ~bus.ex_jump;
        resolve_c      = bus.ex_valid & ~bus.stall & ~shadow & (bus.ex_branch | bus.ex_jump);
        mispredict_c   = bus.ex_jump | (actual_taken_c != bus.ex_pred_taken);
        bht_next_c     = bht[ex_idx_c];
        if (actual_taken_c) begin
            if (bht[ex_idx_c] != 2'b11) bht_next_c = bht[ex_idx_c] + 2'b01;
        end else begin
            if (bht[ex_idx_c] != 2'b00) bht_next_c = bht[ex_idx_c] - 2'b01;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < int'(BHT_ENTRIES); i++) bht[i] <= 2'b01;
            shadow               <= 1'b0;
            bus.redirect_valid   <= 1'b0;
            bus.redirect_pc      <= '0;
            bus.mispredict_count <= '0;
        end else begin
            if (resolve_c && branch_only_c) bht[ex_idx_c] <= bht_next_c;
            if (resolve_c && mispredict_c) begin
                bus.redirect_valid <= 1'b1;
                bus.redirect_pc    <= actual_taken_c ? bus.ex_target : (bus.ex_pc + XLEN'(4));
                if (bus.mispredict_count != {CNT_W{1'b1}})
                    bus.mispredict_count <= bus.mispredict_count + CNT_W'(1);
                shadow             <= 1'b1;
            end else begin
                bus.redirect_valid <= 1'b0;
                shadow             <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_branch_predict_resolve.sv
// Scoreboard bench for branch_predict_resolve: directed scenarios plus random traffic
// checked against a behavioural model of the prediction table and redirect rules.
module tb_branch_predict_resolve;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned BHT   = 16;
    localparam int unsigned CNT_W = 4;
    localparam int          CMAX  = (1 << CNT_W) - 1;

    typedef struct {
        logic [31:0] pc;
        int          cnt;
    } exp_t;

    logic CLK;
    logic RESET;
    int   ncmp;
    int   nfail;
    bit   done;

    int   m_bht [BHT];
    bit   m_shadow;
    int   m_count;
    exp_t q [$];

    branch_predict_resolve_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

    branch_predict_resolve #(.XLEN(XLEN), .BHT_ENTRIES(BHT), .CNT_W(CNT_W)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc / 4) % BHT);
    endfunction

    function automatic bit m_pred(input logic [31:0] pc);
        return m_bht[idx_of(pc)] >= 2;
    endfunction

    function automatic bit m_cond(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        case (f3)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return sa < sb;
            3'd5: return sa >= sb;
            3'd6: return ua < ub;
            3'd7: return ua >= ub;
            default: return 1'b0;
        endcase
    endfunction

    task automatic m_reset();
        for (int i = 0; i < int'(BHT); i++) m_bht[i] = 1;
        m_shadow = 1'b0;
        m_count  = 0;
    endtask

    task automatic check(input string name, input longint act, input longint req);
        ncmp++;
        if (act != req) begin
            nfail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Drive one EX/IF cycle, check the lookup, then advance the model across the coming edge
    task automatic cycle(input bit v, input bit br, input bit j, input logic [2:0] f3,
                         input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] pc,
                         input logic [31:0] tgt, input bit pt, input bit st, input logic [31:0] ppc);
        bit taken, res, mis;
        exp_t e;
        @(negedge CLK);
        bus.ex_valid = v;  bus.ex_branch = br; bus.ex_jump = j; bus.ex_func3 = f3;
        bus.ex_data1 = d1; bus.ex_data2 = d2;  bus.ex_pc = pc;  bus.ex_target = tgt;
        bus.ex_pred_taken = pt; bus.stall = st; bus.pred_pc = ppc;
        #1;
        check("pred_taken", longint'(bus.pred_taken), longint'(m_pred(ppc)));
        taken = j || (br && m_cond(f3, d1, d2));
        res   = v && !st && !m_shadow && (br || j);
        mis   = j ? 1'b1 : (taken != pt);
        if (res && br && !j) begin
            if (taken) m_bht[idx_of(pc)] = (m_bht[idx_of(pc)] == 3) ? 3 : m_bht[idx_of(pc)] + 1;
            else       m_bht[idx_of(pc)] = (m_bht[idx_of(pc)] == 0) ? 0 : m_bht[idx_of(pc)] - 1;
        end
        if (res && mis) begin
            m_count = (m_count == CMAX) ? CMAX : m_count + 1;
            e.pc  = taken ? tgt : pc + 32'd4;
            e.cnt = m_count;
            q.push_back(e);
            m_shadow = 1'b1;
        end else begin
            m_shadow = 1'b0;
        end
    endtask

    task automatic idle(input logic [31:0] ppc);
        cycle(0, 0, 0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 0, 0, ppc);
    endtask

    // Monitor: every redirect pulse must match the oldest expected one, one cycle after issue
    always @(posedge CLK) begin
        exp_t e;
        #1;
        if (RESET && !done) begin
            if (bus.redirect_valid) begin
                if (q.size() == 0) begin
                    check("spurious_redirect", 1, 0);
                end else begin
                    e = q.pop_front();
                    check("redirect_pc", longint'(bus.redirect_pc), longint'(e.pc));
                    check("redirect_count", longint'(bus.mispredict_count), longint'(e.cnt));
                end
            end else if (q.size() != 0) begin
                check("missing_redirect", 0, 1);
                void'(q.pop_front());
            end
            check("mispredict_count", longint'(bus.mispredict_count), longint'(m_count));
        end
    end

    initial begin
        logic [31:0] pcs [8];
        logic [31:0] vals [6];
        logic [31:0] pc, ppc;
        ncmp = 0; nfail = 0; done = 1'b0;
        m_reset();
        bus.pred_pc = 32'h40; bus.ex_valid = 0; bus.ex_branch = 0; bus.ex_jump = 0;
        bus.ex_func3 = 0; bus.ex_data1 = 0; bus.ex_data2 = 0; bus.ex_pc = 0;
        bus.ex_target = 0; bus.ex_pred_taken = 0; bus.stall = 0;
        RESET = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("reset_redirect_valid", longint'(bus.redirect_valid), 0);
        check("reset_redirect_pc", longint'(bus.redirect_pc), 0);
        check("reset_count", longint'(bus.mispredict_count), 0);
        check("reset_pred_0x40", longint'(bus.pred_taken), 0);
        @(negedge CLK);
        RESET = 1'b1;
        idle(32'h40);

        // BEQ taken against a not-taken prediction
        cycle(1, 1, 0, 3'd0, 32'd5, 32'd5, 32'h100, 32'h140, 0, 0, 32'h100);
        idle(32'h100);
        idle(32'h100);
        check("beq_trained_pred", longint'(bus.pred_taken), 1);

        // Signed vs unsigned less-than on -1/1
        cycle(1, 1, 0, 3'd4, 32'hFFFF_FFFF, 32'd1, 32'h300, 32'h380, 0, 0, 32'h300);
        idle(32'h300);
        cycle(1, 1, 0, 3'd6, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'h180, 1, 0, 32'h100);
        idle(32'h100);

        // Saturation up then back down at one PC
        for (int i = 0; i < 4; i++) begin
            cycle(1, 1, 0, 3'd1, 32'd1, 32'd2, 32'h200, 32'h280, m_pred(32'h200), 0, 32'h200);
            idle(32'h200);
        end
        for (int i = 0; i < 2; i++) begin
            cycle(1, 1, 0, 3'd1, 32'd7, 32'd7, 32'h200, 32'h280, m_pred(32'h200), 0, 32'h200);
            idle(32'h200);
        end
        check("desaturated_pred", longint'(bus.pred_taken), 0);

        // JAL then a wrong-path branch in the shadow cycle
        cycle(1, 0, 1, 3'd0, 32'd0, 32'd0, 32'h400, 32'h800, 1, 0, 32'h400);
        cycle(1, 1, 0, 3'd0, 32'd3, 32'd3, 32'h404, 32'h500, 0, 0, 32'h404);
        idle(32'h404);

        // Mispredicting branch held by stall
        for (int i = 0; i < 3; i++)
            cycle(1, 1, 0, 3'd5, 32'd9, 32'd2, 32'h500, 32'h5A0, 0, 1, 32'h500);
        cycle(1, 1, 0, 3'd5, 32'd9, 32'd2, 32'h500, 32'h5A0, 0, 0, 32'h500);
        idle(32'h500);

        // Asynchronous reset while the redirect is high
        cycle(1, 0, 1, 3'd0, 32'd0, 32'd0, 32'h600, 32'h900, 0, 0, 32'h600);
        @(posedge CLK);
        #3;
        check("redirect_before_reset", longint'(bus.redirect_valid), 1);
        bus.ex_valid = 0;
        RESET = 1'b0;
        #1;
        check("async_drop_valid", longint'(bus.redirect_valid), 0);
        check("async_drop_count", longint'(bus.mispredict_count), 0);
        m_reset();
        @(negedge CLK);
        RESET = 1'b1;
        idle(32'h100);
        check("post_reset_pred", longint'(bus.pred_taken), 0);

        // Drive the counter into saturation
        for (int i = 0; i < CMAX + 4; i++) begin
            cycle(1, 0, 1, 3'd0, 32'd0, 32'd0, 32'h700 + 32'(4 * i), 32'hA00, 1, 0, 32'h700);
            idle(32'h700);
        end
        check("count_saturated", longint'(bus.mispredict_count), CMAX);

        // Random traffic over a small PC set so entries alias and retrain
        for (int i = 0; i < 8; i++) pcs[i] = 32'h1000 + 32'($urandom_range(0, 40)) * 4;
        vals[0] = 0; vals[1] = 1; vals[2] = 32'hFFFF_FFFF; vals[3] = 32'h8000_0000;
        vals[4] = 32'h7FFF_FFFF; vals[5] = 5;
        for (int i = 0; i < 3000; i++) begin
            bit v, br, j, pt, st;
            int kind;
            logic [31:0] d1, d2;
            pc   = pcs[$urandom_range(0, 7)];
            ppc  = ($urandom_range(0, 3) == 0) ? $urandom() : pcs[$urandom_range(0, 7)];
            kind = $urandom_range(0, 19);
            v    = ($urandom_range(0, 9) != 0);
            br   = (kind < 13) || (kind == 19);
            j    = (kind >= 16);
            st   = ($urandom_range(0, 4) == 0);
            pt   = ($urandom_range(0, 3) == 0) ? 1'($urandom()) : m_pred(pc);
            d1   = ($urandom_range(0, 1) == 0) ? vals[$urandom_range(0, 5)] : $urandom();
            d2   = ($urandom_range(0, 1) == 0) ? vals[$urandom_range(0, 5)] : $urandom();
            if ($urandom_range(0, 3) == 0) d2 = d1;
            if (i == 1500) begin
                @(negedge CLK);
                RESET = 1'b0;
                #1;
                check("rand_reset_valid", longint'(bus.redirect_valid), 0);
                q.delete();
                m_reset();
                @(negedge CLK);
                RESET = 1'b1;
            end
            cycle(v, br, j, 3'($urandom()), d1, d2, pc, $urandom(), pt, st, ppc);
        end
        idle(32'h0);
        idle(32'h0);
        idle(32'h0);
        check("queue_drained", longint'(q.size()), 0);
        done = 1'b1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
